char_pattern_gen: RTL and testbench

CHAR_PATTERN_GEN -- requirements
Module: char_pattern_gen

---
 rtl/char_pkg.sv | 14 +
 rtl/phase_div.sv | 31 +++
 rtl/char_pattern_gen.sv | 73 +++++++
 tb/tb_char_pattern_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// char_pkg: character index enumeration and default glyph patterns for the 4x4 grid
package char_pkg;
    typedef enum logic [1:0] {CH_A, CH_J, CH_N, CH_X} char_idx_e;
    localparam logic [15:0] PAT_A = 16'h9F8F;
    localparam logic [15:0] PAT_J = 16'h6998;
    localparam logic [15:0] PAT_N = 16'h9DA9;
    localparam logic [15:0] PAT_X = 16'h9679;
    function automatic logic [15:0] default_pattern(int idx);
        return idx == int'(CH_A) ? PAT_A :
               idx == int'(CH_J) ? PAT_J :
               idx == int'(CH_N) ? PAT_N :
               idx == int'(CH_X) ? PAT_X : 16'h0000;
    endfunction
endpackage

// File: rtl/phase_div.sv
// phase_div: programmable half-period divider producing the reference phase and a 1->0 strobe
module phase_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] half_period,
    output logic             phase,
    output logic             phase_fall
);
    logic [DIV_W-1:0] div_cnt;
    logic             term;
    // >= lets a shrunken half_period take effect without waiting for a counter wrap
    assign term = div_cnt >= half_period;
    assign phase_fall = enable && term && phase;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            phase <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            phase <= 1'b0;
        end else if (term) begin
            div_cnt <= '0;
            phase <= ~phase;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/char_pattern_gen.sv
// char_pattern_gen: phase-encoded character pattern driver with manual and auto-sequence selection
module char_pattern_gen
    import char_pkg::*;
#(
    parameter int NUM_PIXELS = 16,
    parameter int NUM_CHARS = 4,
    parameter int DIV_W = 8,
    parameter int DWELL_W = 16,
    localparam int SEL_W = $clog2(NUM_CHARS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      char_select,
    input  logic [DIV_W-1:0]      half_period,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_addr,
    input  logic [NUM_PIXELS-1:0] wr_data,
    output logic [NUM_PIXELS-1:0] pixel_out,
    output logic                  phase,
    output logic [SEL_W-1:0]      cur_char,
    output logic                  char_change
);
    localparam logic [SEL_W:0]   NC = (SEL_W + 1)'(NUM_CHARS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CHARS - 1);
    logic [NUM_PIXELS-1:0] pat [NUM_CHARS];
    logic [DWELL_W-1:0]    dwell_cnt, dwell_next, dmax;
    logic [SEL_W-1:0]      cur_next, cur_prev;
    logic                  mode_q, fall, step;
    phase_div #(.DIV_W(DIV_W)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .half_period(half_period),
        .phase      (phase),
        .phase_fall (fall)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHARS; i++)
                pat[i] <= NUM_PIXELS == 16 ? NUM_PIXELS'(default_pattern(i)) : '0;
        end else if (wr_en && {1'b0, wr_addr} < NC) begin
            pat[wr_addr] <= wr_data;
        end
    end
    // a dwell of 0 behaves as 1; the first auto cycle only clears the count
    always_comb begin
        dmax = dwell == '0 ? DWELL_W'(1) : dwell;
        step = mode && mode_q && fall && dwell_cnt >= dmax - 1'b1;
        dwell_next = (mode && !mode_q) || step ? '0 :
                     mode && fall ? dwell_cnt + 1'b1 : dwell_cnt;
        cur_next = !mode ? ({1'b0, char_select} < NC ? char_select : cur_char) :
                   step ? (cur_char == LAST ? '0 : cur_char + 1'b1) : cur_char;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out <= '0;
            cur_char <= '0;
            cur_prev <= '0;
            dwell_cnt <= '0;
            mode_q <= 1'b0;
        end else begin
            pixel_out <= enable ? pat[cur_char] ^ {NUM_PIXELS{~phase}} : '0;
            cur_char <= cur_next;
            cur_prev <= cur_char;
            dwell_cnt <= dwell_next;
            mode_q <= mode;
        end
    end
    assign char_change = cur_char != cur_prev;
endmodule

// File: tb/tb_char_pattern_gen.sv
// tb_char_pattern_gen: table vectors, directed corner sequences and random stimulus vs a reference model
module tb_char_pattern_gen;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, mode = 1'b0, wr_en = 1'b0;
    logic [1:0]  char_select = '0, wr_addr = '0;
    logic [7:0]  half_period = '0;
    logic [15:0] dwell = '0, wr_data = '0;
    logic [15:0] pix0, pix1;
    logic        ph0, ph1, chg0, chg1;
    logic [1:0]  cur0, cur1;
    int          checks = 0, errors = 0;

    char_pattern_gen dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .char_select(char_select),
        .half_period(half_period), .dwell(dwell), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .pixel_out(pix0), .phase(ph0), .cur_char(cur0), .char_change(chg0)
    );
    char_pattern_gen #(.NUM_CHARS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .char_select(char_select),
        .half_period(half_period), .dwell(dwell), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .pixel_out(pix1), .phase(ph1), .cur_char(cur1), .char_change(chg1)
    );

    always #5 clk = ~clk;

    int          m_cnt;
    bit          m_ph, m_mq;
    int          m_cur [2], m_dwc [2];
    bit [15:0]   m_pat [2][4];
    bit [15:0]   m_pix [2];
    bit          m_chg [2];

    task automatic m_reset();
        m_cnt = 0; m_ph = 0; m_mq = 0;
        for (int k = 0; k < 2; k++) begin
            m_cur[k] = 0; m_dwc[k] = 0; m_pix[k] = 0; m_chg[k] = 0;
            m_pat[k][0] = 16'h9F8F; m_pat[k][1] = 16'h6998;
            m_pat[k][2] = 16'h9DA9; m_pat[k][3] = k == 0 ? 16'h9679 : 16'h0000;
        end
    endtask

    // one clock of behaviour: instance 0 stores 4 characters, instance 1 stores 3
    task automatic m_tick();
        int nc, dmax, oldc;
        bit fall;
        if (!rst_n) begin
            m_reset();
            return;
        end
        fall = enable && m_cnt >= int'(half_period) && m_ph;
        dmax = dwell == 0 ? 1 : int'(dwell);
        for (int k = 0; k < 2; k++) begin
            nc = 4 - k;
            oldc = m_cur[k];
            for (int i = 0; i < 16; i++)
                m_pix[k][i] = enable && (m_pat[k][oldc][i] ? m_ph : !m_ph);
            if (wr_en && int'(wr_addr) < nc) m_pat[k][wr_addr] = wr_data;
            if (!mode) begin
                if (int'(char_select) < nc) m_cur[k] = int'(char_select);
            end else if (!m_mq) begin
                m_dwc[k] = 0;
            end else if (fall) begin
                m_dwc[k]++;
                if (m_dwc[k] >= dmax) begin
                    m_dwc[k] = 0;
                    m_cur[k] = (m_cur[k] + 1) % nc;
                end
            end
            m_chg[k] = m_cur[k] != oldc;
        end
        if (!enable) begin
            m_cnt = 0; m_ph = 0;
        end else if (m_cnt >= int'(half_period)) begin
            m_cnt = 0; m_ph = !m_ph;
        end else begin
            m_cnt++;
        end
        m_mq = mode;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_tick();
        @(negedge clk);
        chk("mdl4_pix", 32'(pix0), 32'(m_pix[0]));
        chk("mdl4_ctl", 32'({ph0, cur0, chg0}), 32'({m_ph, 2'(m_cur[0]), m_chg[0]}));
        chk("mdl3_pix", 32'(pix1), 32'(m_pix[1]));
        chk("mdl3_ctl", 32'({ph1, cur1, chg1}), 32'({m_ph, 2'(m_cur[1]), m_chg[1]}));
    endtask

    typedef struct {
        bit        en;
        bit [1:0]  sel;
        bit [15:0] pix;
        bit        ph;
        bit [1:0]  cur;
        bit        chg;
    } vec_t;
    vec_t tbl [10];

    initial begin
        int   rs [4];
        int   ev_cur [4], ev_t [4];
        int   nr, ne;
        bit   last, ph_a;
        tbl[0] = '{1, 0, 16'h6070, 1, 0, 0};
        tbl[1] = '{1, 0, 16'h9F8F, 0, 0, 0};
        tbl[2] = '{1, 0, 16'h6070, 1, 0, 0};
        tbl[3] = '{1, 1, 16'h9F8F, 0, 1, 1};
        tbl[4] = '{1, 1, 16'h9667, 1, 1, 0};
        tbl[5] = '{1, 1, 16'h6998, 0, 1, 0};
        tbl[6] = '{0, 3, 16'h0000, 0, 3, 1};
        tbl[7] = '{0, 3, 16'h0000, 0, 3, 0};
        tbl[8] = '{1, 2, 16'h6986, 1, 2, 1};
        tbl[9] = '{1, 2, 16'h9DA9, 0, 2, 0};
        m_reset();
        repeat (2) step();
        chk("reset_outs", 32'({pix0, ph0, cur0, chg0}), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enable = tbl[i].en;
            char_select = tbl[i].sel;
            step();
            chk($sformatf("tbl%0d_pix", i), 32'(pix0), 32'(tbl[i].pix));
            chk($sformatf("tbl%0d_ph", i), 32'(ph0), 32'(tbl[i].ph));
            chk($sformatf("tbl%0d_cur", i), 32'(cur0), 32'(tbl[i].cur));
            chk($sformatf("tbl%0d_chg", i), 32'(chg0), 32'(tbl[i].chg));
        end
        char_select = 2'd1;
        step();
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'hFFFF;
        step();
        ph_a = m_ph;
        wr_addr = 2'd3;
        step();
        chk("wr_pix", 32'(pix0), ph_a ? 32'hFFFF : 32'h0);
        wr_en = 1'b0;
        char_select = 2'd3;
        repeat (4) step();
        half_period = 8'd3;
        nr = 0; last = ph0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ph0 && !last && nr < 4) begin
                rs[nr] = i;
                nr++;
            end
            last = ph0;
        end
        chk("div_rises", 32'(nr), 32'd4);
        chk("div_period", nr == 4 ? 32'(rs[3] - rs[2]) : 32'h0, 32'd8);
        enable = 1'b0;
        step();
        chk("dis_outs", 32'({pix0, ph0}), 32'h0);
        enable = 1'b1; half_period = 8'd1; dwell = 16'd2; char_select = 2'd0;
        repeat (2) step();
        mode = 1'b1;
        ne = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (chg0) begin
                if (ne < 4) begin
                    ev_cur[ne] = int'(cur0);
                    ev_t[ne] = i;
                end
                ne++;
            end
        end
        chk("auto_events", 32'(ne >= 4), 32'd1);
        for (int j = 0; j < 4; j++) chk($sformatf("auto_cur%0d", j), 32'(ev_cur[j]), 32'((j + 1) % 4));
        for (int j = 1; j < 4; j++) chk($sformatf("auto_gap%0d", j), 32'(ev_t[j] - ev_t[j-1]), 32'd8);
        mode = 1'b0; char_select = 2'd2;
        step();
        chk("m10_cur", 32'(cur0), 32'd2);
        mode = 1'b1; dwell = 16'd3;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'({pix0, ph0, cur0, chg0}), 32'h0);
        repeat (2) step();
        rst_n = 1'b1; mode = 1'b0; half_period = 8'd0; char_select = 2'd1;
        repeat (2) step();
        chk("rst_pat", 32'(pix0 == 16'h6998 || pix0 == 16'h9667), 32'd1);
        char_select = 2'd3;
        repeat (3) step();
        for (int i = 0; i < 800; i++) begin
            rst_n = $urandom_range(0, 99) != 0;
            enable = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            char_select = 2'($urandom_range(0, 3));
            half_period = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) dwell = 16'($urandom_range(0, 3));
            wr_en = $urandom_range(0, 7) == 0;
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 16'($urandom);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
